// File: rtl/lcd_time_scheduler.sv
// lcd_time_scheduler: builds one 11-transfer LCD frame (address command plus
// "MM:SS.CC M") per refresh request and streams it over a valid/ready link.
// The time and mode are snapshotted at frame start, so a frame never tears.
module lcd_time_scheduler (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [2:0]  state_in,
  input  logic [23:0] live_bcd,
  input  logic        refresh_tick,
  input  logic        lcd_ready,
  output logic        lcd_valid,
  output logic        lcd_rs,
  output logic [7:0]  lcd_data,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [7:0] LCD_ADDR = 8'h80;

  typedef enum logic {S_IDLE, S_SEND} fsm_t;

  fsm_t        r_fsm, w_fsm_nxt;
  logic [2:0]  r_prev_state;
  logic [23:0] r_lap_bcd;
  logic        r_pending;
  logic [23:0] r_snap_bcd;
  logic [7:0]  r_snap_mode;
  logic [3:0]  r_idx;

  logic [2:0]  w_state;
  logic        w_lap_mode;
  logic        w_lap_capture;
  logic [23:0] w_lap_nxt;
  logic        w_set;
  logic        w_start;
  logic        w_accept;
  logic        w_last;
  logic [3:0]  w_idx_nxt;
  logic [7:0]  w_mode;

  // BCD nibble to ASCII; anything outside 0-9 shows as '?'
  function automatic logic [7:0] f_digit(input logic [3:0] nib);
    logic [7:0] c;
    if (nib > 4'd9) c = 8'h3F;
    else            c = 8'h30 + {4'h0, nib};
    return c;
  endfunction

  // Byte for frame item idx, built from the frame snapshot
  function automatic logic [7:0] f_item(input logic [3:0] idx,
                                        input logic [23:0] bcd,
                                        input logic [7:0] mode);
    logic [7:0] c;
    case (idx)
      4'd0:    c = LCD_ADDR;
      4'd1:    c = f_digit(bcd[23:20]);
      4'd2:    c = f_digit(bcd[19:16]);
      4'd3:    c = 8'h3A;
      4'd4:    c = f_digit(bcd[15:12]);
      4'd5:    c = f_digit(bcd[11:8]);
      4'd6:    c = 8'h2E;
      4'd7:    c = f_digit(bcd[7:4]);
      4'd8:    c = f_digit(bcd[3:0]);
      4'd9:    c = 8'h20;
      default: c = mode;
    endcase
    return c;
  endfunction

  // Codes 5-7 behave exactly like "cleared"
  assign w_state       = (state_in > 3'd4) ? 3'd0 : state_in;
  assign w_lap_mode    = (w_state == 3'd3) || (w_state == 3'd4);
  assign w_lap_capture = (w_state == 3'd3) && (r_prev_state == 3'd2);
  // Forwarded lap value so a frame starting on the 2->3 cycle sees the capture
  assign w_lap_nxt     = w_lap_capture      ? live_bcd :
                         (w_state == 3'd0)  ? 24'h0    : r_lap_bcd;
  assign w_set         = refresh_tick || (w_state != r_prev_state);
  assign w_start       = (r_fsm == S_IDLE) && r_pending;
  assign w_accept      = lcd_valid && lcd_ready;
  assign w_last        = (r_fsm == S_SEND) && w_accept && (r_idx == 4'd10);
  assign w_idx_nxt     = r_idx + 4'd1;

  // Mode letter shown in the last column
  always_comb begin
    w_mode = 8'h2D;
    case (w_state)
      3'd1:       w_mode = 8'h53;
      3'd2:       w_mode = 8'h52;
      3'd3, 3'd4: w_mode = 8'h4C;
      default:    w_mode = 8'h2D;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (reset_in) r_fsm <= S_IDLE;
    else          r_fsm <= w_fsm_nxt;
  end

  // FSM next state: idle until a request is pending, send until item 10 is taken
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (r_pending) w_fsm_nxt = S_SEND;
      S_SEND:  if (w_last)    w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // Lap latch, request merging, snapshot and the transfer stream
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_prev_state <= 3'd0;
      r_lap_bcd    <= 24'h0;
      r_pending    <= 1'b1;
      r_snap_bcd   <= 24'h0;
      r_snap_mode  <= 8'h2D;
      r_idx        <= 4'd0;
      lcd_valid    <= 1'b0;
      lcd_rs       <= 1'b0;
      lcd_data     <= 8'h00;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      r_prev_state <= w_state;
      r_lap_bcd    <= w_lap_nxt;
      // a new request in the start cycle survives into the next frame
      r_pending    <= w_set || (r_pending && !w_start);
      frame_done   <= 1'b0;
      if (w_start) begin
        r_snap_bcd  <= w_lap_mode ? w_lap_nxt : live_bcd;
        r_snap_mode <= w_mode;
        r_idx       <= 4'd0;
        lcd_valid   <= 1'b1;
        lcd_rs      <= 1'b0;
        lcd_data    <= LCD_ADDR;
        busy        <= 1'b1;
      end else if ((r_fsm == S_SEND) && w_accept) begin
        if (r_idx == 4'd10) begin
          lcd_valid  <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          r_idx    <= w_idx_nxt;
          lcd_rs   <= 1'b1;
          lcd_data <= f_item(w_idx_nxt, r_snap_bcd, r_snap_mode);
        end
      end
    end
  end

endmodule
